inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Parametrised, run-time loadable instruction memory for the CPU fetch stage. It holds up to 2^ADDR_WIDTH instructions of INST_WIDTH bits and serves them through a registered, one-cycle-latency fetch port. A byte-serial load port streams a program in after reset, so no program is hard-coded into the memory. It sits between the boot/UART byte source and the CPU program counter.

## Interface
- INST_WIDTH, 32, instruction width in bits; 8..64.
- ADDR_WIDTH, 8, index width; DEPTH = 2^ADDR_WIDTH words.
- BYTES, derived = ceil(INST_WIDTH/8), bytes per instruction on the load port.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_start  in  1  one-cycle pulse that starts a program load; sampled only in IDLE.
- load_len  in  ADDR_WIDTH+1  number of instructions to load; sampled with load_start.
- load_byte_valid  in  1  source has a byte on load_byte.
- load_byte  in  8  program byte; little-endian within each instruction.
- load_byte_ready  out  1  block accepts a byte this cycle.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when a load completes.
- fetch_en  in  1  fetch request for fetch_addr.
- fetch_addr  in  32  instruction index from the PC.
- inst  out  INST_WIDTH  fetched instruction (registered).
- inst_valid  out  1  inst holds the result of the fetch issued in the previous cycle.

## Operation
- States: IDLE, LOAD.
- IDLE -> LOAD: load_start=1 and load_len != 0. Latch len = min(load_len, DEPTH). Clear waddr and the byte counter.
- IDLE with load_start=1 and load_len=0: load_done pulses next cycle. State stays IDLE.
- LOAD:
  - load_byte_ready=1. A byte transfers when load_byte_valid && load_byte_ready.
  - Byte k (k = 0..BYTES-1) of the instruction goes to bits [8k+7:8k]. Bits above INST_WIDTH-1 in the last byte are discarded.
  - On the transfer of byte BYTES-1, write the assembled word to mem[waddr], increment waddr and reset the byte counter.
  - When the written word is number len-1: go to IDLE and pulse load_done for one cycle.
- load_start while in LOAD is ignored.
- Fetch, in IDLE only: fetch_en=1 gives inst = mem[fetch_addr] on the next cycle with inst_valid=1.
  - If fetch_addr >= DEPTH, inst = 0 (NOP) with inst_valid=1.
- Fetch while in LOAD: inst_valid=0 and inst holds its value. Read-during-write therefore cannot occur.
- fetch_en=0: inst_valid=0 next cycle, inst holds its value.
- Memory array is not reset.
  - Words written before a reset are retained.
  - Never-written words are undefined; the bench must not check them.

## Timing
- Reset values: load_byte_ready=0, load_busy=0, load_done=0, inst=0, inst_valid=0. State = IDLE, waddr=0, byte counter=0.
- rst during LOAD: next cycle is IDLE. The partially assembled word is discarded. Words already written stay in memory. No load_done pulse.
- load_busy is high from the cycle after load_start until the cycle load_done is high; it is low in that cycle.
- Load throughput: one byte per cycle when valid is held high. A len-word load takes len*BYTES cycles of LOAD.
- Fetch latency: exactly 1 cycle; back-to-back fetches give one instruction per cycle.
- A fetch in the same cycle as the LOAD->IDLE transition is not served: inst_valid=0 next cycle. A fetch in the first IDLE cycle after that is served.
- load_start and fetch_en in the same IDLE cycle: the fetch is served, then the state enters LOAD.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> all outputs at their reset values, and load_byte_ready=0.
- Basic load and fetch (INST_WIDTH=32):
  - Stimulus: load_len=3, bytes 78 56 34 12, EF BE AD DE, 01 00 00 00 with continuous valid.
  - Expected: load_done exactly 12 cycles after LOAD entry.
  - Then fetch 0,1,2 back-to-back -> 0x12345678, 0xDEADBEEF, 0x00000001, each one cycle after its request.
- Gapped valid plus fetch during load: toggle load_byte_valid every other cycle and keep fetch_en=1 throughout.
  - Expected: inst_valid=0 for the whole load; words are written correctly; load_done after 24 cycles.
- Out-of-range and zero length:
  - fetch_addr=256 (ADDR_WIDTH=8) -> inst=0, inst_valid=1.
  - load_len=0 -> load_done the next cycle, load_busy never high.
- Reset mid-load: load len=2, assert rst after 6 bytes.
  - Expected: IDLE, no load_done, word 0 retained.
  - A new load of len=1 then overwrites word 0 correctly.
- Odd width (INST_WIDTH=18): load bytes 0xFF, 0xFF, 0xFF -> fetch returns 0x3FFFF.

Source files
------------

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: byte-serial loadable instruction memory with a registered one-cycle fetch port
module inst_mem_loader #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_byte_ready,
    output logic                  load_busy,
    output logic                  load_done,
    input  logic                  fetch_en,
    input  logic [31:0]           fetch_addr,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid
);
    localparam int BYTES = (INST_WIDTH + 7) / 8;
    localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    typedef enum logic {IDLE, LOAD} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [INST_WIDTH-1:0] word_q, word_d, inst_q, inst_d, asm_word;
    logic                  done_q, done_d, inst_valid_q, inst_valid_d;
    logic                  wen, last_byte, last_word;
    logic [INST_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    assign last_byte = bcnt_q == BW'(BYTES - 1);
    assign last_word = {1'b0, waddr_q} == len_q - 1'b1;
    assign wen = state_q == LOAD && load_byte_valid && last_byte && !rst;
    always_comb begin
        asm_word = word_q;
        for (int i = 0; i < INST_WIDTH; i++)
            if (i / 8 == int'(bcnt_q)) asm_word[i] = load_byte[3'(i % 8)];
    end
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        waddr_d = waddr_q;
        bcnt_d = bcnt_q;
        word_d = word_q;
        done_d = 1'b0;
        inst_valid_d = state_q == IDLE && fetch_en;
        inst_d = !inst_valid_d ? inst_q :
                 (fetch_addr >> ADDR_WIDTH) != 32'd0 ? '0 : mem[fetch_addr[ADDR_WIDTH-1:0]];
        if (state_q == IDLE && load_start) begin
            done_d = load_len == '0;
            state_d = load_len == '0 ? IDLE : LOAD;
            len_d = load_len > DEPTH ? DEPTH : load_len;
            waddr_d = '0;
            bcnt_d = '0;
        end else if (state_q == LOAD && load_byte_valid) begin
            word_d = asm_word;
            bcnt_d = last_byte ? '0 : bcnt_q + 1'b1;
            waddr_d = last_byte ? waddr_q + 1'b1 : waddr_q;
            done_d = last_byte && last_word;
            state_d = last_byte && last_word ? IDLE : LOAD;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q <= '0;
            waddr_q <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            done_q <= 1'b0;
            inst_q <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            waddr_q <= waddr_d;
            bcnt_q <= bcnt_d;
            word_q <= word_d;
            done_q <= done_d;
            inst_q <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end
    // memory contents deliberately survive reset
    always_ff @(posedge clk)
        if (wen) mem[waddr_q] <= asm_word;
    assign load_byte_ready = state_q == LOAD;
    assign load_busy = state_q == LOAD;
    assign load_done = done_q;
    assign inst = inst_q;
    assign inst_valid = inst_valid_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized scoreboard bench for the 32-bit and 18-bit loader variants
module tb_inst_mem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst;
    logic        load_start, load_byte_valid, fetch_en;
    logic [8:0]  load_len;
    logic [7:0]  load_byte;
    logic [31:0] fetch_addr, inst;
    logic        load_byte_ready, load_busy, load_done, inst_valid;
    logic        b_load_start, b_load_byte_valid, b_fetch_en;
    logic [8:0]  b_load_len;
    logic [7:0]  b_load_byte;
    logic [31:0] b_fetch_addr;
    logic [17:0] b_inst;
    logic        b_load_byte_ready, b_load_busy, b_load_done, b_inst_valid;

    inst_mem_loader #(.INST_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .load_byte_valid(load_byte_valid), .load_byte(load_byte),
        .load_byte_ready(load_byte_ready), .load_busy(load_busy), .load_done(load_done),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .inst(inst), .inst_valid(inst_valid));

    inst_mem_loader #(.INST_WIDTH(18), .ADDR_WIDTH(8)) dut18 (
        .clk(clk), .rst(rst), .load_start(b_load_start), .load_len(b_load_len),
        .load_byte_valid(b_load_byte_valid), .load_byte(b_load_byte),
        .load_byte_ready(b_load_byte_ready), .load_busy(b_load_busy), .load_done(b_load_done),
        .fetch_en(b_fetch_en), .fetch_addr(b_fetch_addr), .inst(b_inst), .inst_valid(b_inst_valid));

    typedef struct { int due; logic [31:0] val; } exp_t;
    exp_t        q32[$], q18[$];
    logic [7:0]  stim[$];
    logic [31:0] model[256];
    bit          written[256];
    int          cyc = 0, n_cmp = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every cycle, valid must match whether an expectation is due
    always @(negedge clk) begin
        bit e;
        if (cyc > 0) begin
            e = q32.size() != 0 && q32[0].due == cyc;
            check("inst_valid32", {31'b0, inst_valid}, {31'b0, e});
            if (e) begin
                if (inst_valid) check("inst32", inst, q32[0].val);
                void'(q32.pop_front());
            end
            e = q18.size() != 0 && q18[0].due == cyc;
            check("inst_valid18", {31'b0, b_inst_valid}, {31'b0, e});
            if (e) begin
                if (b_inst_valid) check("inst18", {14'b0, b_inst}, q18[0].val);
                void'(q18.pop_front());
            end
        end
    end

    task automatic fetch32(input logic [31:0] a);
        fetch_en = 1'b1;
        fetch_addr = a;
        q32.push_back('{due: cyc + 1, val: a >= 256 ? 32'd0 : model[a[7:0]]});
        tick;
        fetch_en = 1'b0;
    endtask

    // mode: 0 continuous valid, 1 toggling valid starting low, 2 random gaps
    task automatic load32(input int len_in, input int mode, input bit fetching, output int cycles);
        int nw, total, sent;
        bit v;
        nw = len_in > 256 ? 256 : len_in;
        total = nw * 4;
        while (stim.size() < total) stim.push_back(8'($urandom));
        load_start = 1'b1;
        load_len = 9'(len_in);
        if (fetching) begin
            fetch_en = 1'b1;
            fetch_addr = 32'd0;
            q32.push_back('{due: cyc + 1, val: model[0]});
        end
        tick;
        check("busy_entry", {31'b0, load_busy}, 32'd1);
        cycles = 0;
        sent = 0;
        while (sent < total && cycles < 5000) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? cycles % 2 == 1 : $urandom_range(0, 2) != 0;
            load_byte_valid = v;
            load_byte = v ? stim[sent] : 8'($urandom);
            load_start = $urandom_range(0, 7) == 0;
            load_len = 9'($urandom);
            if (fetching) fetch_addr = $urandom;
            check("ready", {31'b0, load_byte_ready}, 32'd1);
            tick;
            cycles++;
            if (v) sent++;
            check("load_done", {31'b0, load_done}, {31'b0, sent == total});
            check("load_busy", {31'b0, load_busy}, {31'b0, sent != total});
        end
        load_byte_valid = 1'b0;
        load_start = 1'b0;
        fetch_en = 1'b0;
        for (int w = 0; w < nw; w++) begin
            model[w] = 32'(stim[4*w]) | 32'(stim[4*w+1]) << 8 | 32'(stim[4*w+2]) << 16 | 32'(stim[4*w+3]) << 24;
            written[w] = 1'b1;
        end
        stim.delete();
    endtask

    task automatic load18(input logic [7:0] b[$]);
        int nw;
        logic [31:0] w18[$];
        nw = b.size() / 3;
        b_load_start = 1'b1;
        b_load_len = 9'(nw);
        tick;
        b_load_start = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            b_load_byte_valid = 1'b1;
            b_load_byte = b[i];
            tick;
            check("done18", {31'b0, b_load_done}, {31'b0, i == b.size() - 1});
        end
        b_load_byte_valid = 1'b0;
        for (int w = 0; w < nw; w++)
            w18.push_back((32'(b[3*w]) + (32'(b[3*w+1]) << 8) + (32'(b[3*w+2]) << 16)) % 32'h40000);
        for (int w = 0; w < nw; w++) begin
            b_fetch_en = 1'b1;
            b_fetch_addr = 32'(w);
            q18.push_back('{due: cyc + 1, val: w18[w]});
            tick;
        end
        b_fetch_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int c, len;
        logic [7:0] b18[$];
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_start = 1'($urandom); load_len = 9'($urandom); load_byte_valid = 1'($urandom);
            load_byte = 8'($urandom); fetch_en = 1'($urandom); fetch_addr = $urandom;
            b_load_start = 1'($urandom); b_load_len = 9'($urandom); b_load_byte_valid = 1'($urandom);
            b_load_byte = 8'($urandom); b_fetch_en = 1'($urandom); b_fetch_addr = $urandom;
            tick;
            check("rst_ready", {31'b0, load_byte_ready}, 32'd0);
            check("rst_busy", {31'b0, load_busy}, 32'd0);
            check("rst_done", {31'b0, load_done}, 32'd0);
            check("rst_inst", inst, 32'd0);
            check("rst_inst18", {14'b0, b_inst}, 32'd0);
        end
        rst = 1'b0;
        load_start = 1'b0; load_byte_valid = 1'b0; fetch_en = 1'b0; load_len = '0; load_byte = '0; fetch_addr = '0;
        b_load_start = 1'b0; b_load_byte_valid = 1'b0; b_fetch_en = 1'b0; b_load_len = '0; b_load_byte = '0; b_fetch_addr = '0;
        tick;
        check("idle_ready", {31'b0, load_byte_ready}, 32'd0);

        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
        load32(3, 0, 1'b0, c);
        check("basic_cycles", c, 32'd12);
        for (int a = 0; a < 3; a++) fetch32(a);

        load32(3, 1, 1'b1, c);
        check("gapped_cycles", c, 32'd24);
        for (int a = 0; a < 3; a++) fetch32(a);

        fetch32(32'd256);
        fetch32(32'hFFFF_FFFF);
        fetch32(32'd1000);

        load_start = 1'b1;
        load_len = '0;
        tick;
        load_start = 1'b0;
        check("zero_done", {31'b0, load_done}, 32'd1);
        check("zero_busy", {31'b0, load_busy}, 32'd0);
        tick;
        check("zero_done_pulse", {31'b0, load_done}, 32'd0);
        check("zero_busy2", {31'b0, load_busy}, 32'd0);

        load_start = 1'b1;
        load_len = 9'd2;
        tick;
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stim.push_back(8'($urandom));
            load_byte_valid = 1'b1;
            load_byte = stim[i];
            tick;
            check("mid_done", {31'b0, load_done}, 32'd0);
        end
        model[0] = {stim[3], stim[2], stim[1], stim[0]};
        stim.delete();
        load_byte_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, load_busy}, 32'd0);
        check("rst_mid_done", {31'b0, load_done}, 32'd0);
        tick;
        check("rst_mid_done2", {31'b0, load_done}, 32'd0);
        fetch32(0);
        load32(1, 0, 1'b0, c);
        check("reload_cycles", c, 32'd4);
        fetch32(0);

        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 12);
            load32(len, $urandom_range(0, 2), written[0] && $urandom_range(0, 1) == 1, c);
            for (int k = 0; k < 8; k++)
                fetch32($urandom_range(0, 9) == 0 ? 32'd256 + $urandom_range(0, 999) : 32'($urandom_range(0, len - 1)));
        end

        load32(300, 0, 1'b0, c);
        check("clamp_cycles", c, 32'd1024);
        fetch32(255);
        fetch32(0);
        for (int k = 0; k < 6; k++) fetch32($urandom_range(0, 255));

        b18 = '{8'hFF, 8'hFF, 8'hFF};
        load18(b18);
        b18.delete();
        for (int i = 0; i < 12; i++) b18.push_back(8'($urandom));
        load18(b18);

        repeat (3) tick;
        check("q32_drained", q32.size(), 32'd0);
        check("q18_drained", q18.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
